prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/core_pkg.sv | 8 +
 rtl/prefetch_fifo.sv | 35 +++
 rtl/prefetch_unit.sv | 87 ++++++++
 tb/tb_prefetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: prefetch FSM state type and default parameter values.
package core_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, CORE} pf_state_t;
    localparam int PF_ADDR_W   = 16;
    localparam int PF_DATA_W   = 8;
    localparam int PF_DEPTH    = 4;
    localparam int PF_RESET_PC = 0;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: first-word-fall-through queue; flush overrides push and pop.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                         ph1,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_pop;
    assign do_pop = pop && count != '0;
    assign rdata  = mem[rd_ptr];
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
    always_ff @(posedge ph1)
        if (push && !flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: prefetch queue sharing one memory port with core accesses, core first.
// Define PREFETCH_PERF_EN to add the saturating perf_wait stall counter.
module prefetch_unit import core_pkg::*; #(
    parameter int                 ADDR_W   = PF_ADDR_W,
    parameter int                 DATA_W   = PF_DATA_W,
    parameter int                 DEPTH    = PF_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(PF_RESET_PC)
) (
    input  logic                        ph1,
    input  logic                        reset,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_read_en,
    output logic                        mem_write_en,
    input  logic [DATA_W-1:0]           mem_data_in,
    output logic [DATA_W-1:0]           mem_data_out,
    input  logic                        mem_ready,
    input  logic                        core_req,
    input  logic                        core_we,
    input  logic [ADDR_W-1:0]           core_addr,
    input  logic [DATA_W-1:0]           core_wdata,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        core_ack,
    input  logic                        flush,
    input  logic [ADDR_W-1:0]           flush_pc,
    output logic                        q_valid,
    output logic [DATA_W-1:0]           q_data,
    output logic [ADDR_W-1:0]           q_pc,
    input  logic                        q_pop,
    output logic [$clog2(DEPTH+1)-1:0]  q_count
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]                 perf_wait
`endif
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    pf_state_t           state, state_nxt;
    logic [ADDR_W-1:0]   fetch_ptr, fetch_ptr_nxt, fetch_addr;
    logic                discard, push, space, load;
    assign push          = state == FETCH && mem_ready && !discard && !flush;
    // Space is judged on the registered count only, so q_pop never reaches mem_*.
    assign space         = push ? q_count < FULL - CW'(1) : q_count < FULL;
    assign fetch_ptr_nxt = flush ? flush_pc : push ? fetch_ptr + ADDR_W'(1) : fetch_ptr;
    assign load          = state_nxt == FETCH && !(state == FETCH && !mem_ready);
    assign core_rdata    = mem_data_in;
    assign q_valid       = q_count != '0;
    always_comb begin
        state_nxt = state;
        if (state == CORE) state_nxt = mem_ready ? IDLE : CORE;
        else if (state == IDLE || mem_ready) state_nxt = core_req ? CORE : space ? FETCH : IDLE;
        mem_addr     = state == CORE ? core_addr : fetch_addr;
        mem_read_en  = state == FETCH || (state == CORE && !core_we);
        mem_write_en = state == CORE && core_we;
        mem_data_out = state == CORE ? core_wdata : '0;
        core_ack     = state == CORE && mem_ready;
    end
    // fetch_addr is latched at issue so a flush cannot move an access in flight.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_ptr  <= RESET_PC;
            fetch_addr <= RESET_PC;
            discard    <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_ptr <= fetch_ptr_nxt;
            if (load) fetch_addr <= fetch_ptr_nxt;
            discard   <= state == FETCH && !mem_ready && (discard || flush);
        end
    end
    prefetch_fifo #(.DEPTH(DEPTH), .W(DATA_W + ADDR_W)) u_fifo (
        .ph1   (ph1),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (q_pop),
        .wdata ({mem_data_in, fetch_addr}),
        .rdata ({q_data, q_pc}),
        .count (q_count)
    );
`ifdef PREFETCH_PERF_EN
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) perf_wait <= '0;
        else if (state != IDLE && !mem_ready && perf_wait != 16'hFFFF) perf_wait <= perf_wait + 16'd1;
    end
`endif
endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed scenarios plus a randomized run against a queue-based model.
module tb_prefetch_unit;
    localparam int AW = 16, DW = 8, DEPTH = 4, CW = $clog2(DEPTH + 1);
    logic ph1 = 0, reset;
    logic [AW-1:0] mem_addr, core_addr, flush_pc, q_pc;
    logic mem_read_en, mem_write_en, mem_ready, core_req, core_we, core_ack, flush, q_valid, q_pop;
    logic [DW-1:0] mem_data_in, mem_data_out, core_wdata, core_rdata, q_data, salt;
    logic [CW-1:0] q_count;
`ifdef PREFETCH_PERF_EN
    logic [15:0] perf_wait;
`endif
    int tests = 0, fails = 0;

    always #5 ph1 = ~ph1;
    // Memory returns a pattern derived from the address plus a per-cycle salt.
    assign mem_data_in = mem_addr[7:0] ^ mem_addr[15:8] ^ salt;

    prefetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(16'h0200)) dut (
        .ph1(ph1), .reset(reset),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack),
        .flush(flush), .flush_pc(flush_pc),
        .q_valid(q_valid), .q_data(q_data), .q_pc(q_pc), .q_pop(q_pop), .q_count(q_count)
`ifdef PREFETCH_PERF_EN
        , .perf_wait(perf_wait)
`endif
    );

    task automatic test_reset;
        reset = 1; mem_ready = 1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        flush = 0; flush_pc = '0; q_pop = 0; salt = '0;
        #12;
        tests++; if (q_count !== 0) begin fails++; $display("FAIL reset_count got=%0d exp=0", q_count); end
        tests++; if (q_valid !== 0) begin fails++; $display("FAIL reset_valid got=%b exp=0", q_valid); end
        tests++; if ({mem_read_en, mem_write_en, core_ack} !== 3'b000) begin fails++; $display("FAIL reset_mem got=%b exp=000", {mem_read_en, mem_write_en, core_ack}); end
        @(negedge ph1); reset = 0;
    endtask

    task automatic test_fill;
        logic [AW-1:0] seen[$];
        repeat (12) begin
            @(negedge ph1); #1;
            if (mem_read_en && mem_ready) seen.push_back(mem_addr);
        end
        tests++; if (seen.size() != 4) begin fails++; $display("FAIL fill_fetches got=%0d exp=4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            tests++; if (seen[i] !== 16'(16'h0200 + i)) begin fails++; $display("FAIL fill_addr%0d got=%h exp=%h", i, seen[i], 16'(16'h0200 + i)); end
        end
        tests++; if (q_count !== 4 || mem_read_en !== 0) begin fails++; $display("FAIL fill_full got=%0d/%b exp=4/0", q_count, mem_read_en); end
        tests++; if ({q_valid, q_pc, q_data} !== {1'b1, 16'h0200, 8'h02}) begin fails++; $display("FAIL fill_head got=%b/%h/%h exp=1/0200/02", q_valid, q_pc, q_data); end
    endtask

    task automatic test_wait;
        logic [AW-1:0] seen[$];
        int wc = 0;
        @(negedge ph1); flush = 1; flush_pc = 16'h0300; mem_ready = 0;
        @(negedge ph1); flush = 0;
        repeat (24) begin
            @(negedge ph1);
            if (mem_read_en) begin mem_ready = (wc == 3); wc = mem_ready ? 0 : wc + 1; end
            else begin mem_ready = 0; wc = 0; end
            #1;
            if (mem_read_en) seen.push_back(mem_addr);
        end
        tests++; if (seen.size() != 16) begin fails++; $display("FAIL wait_cycles got=%0d exp=16", seen.size()); end
        for (int i = 0; i < 16 && i < seen.size(); i++) begin
            tests++; if (seen[i] !== 16'(16'h0300 + i / 4)) begin fails++; $display("FAIL wait_addr%0d got=%h exp=%h", i, seen[i], 16'(16'h0300 + i / 4)); end
        end
`ifdef PREFETCH_PERF_EN
        tests++; if (perf_wait !== 16'd12) begin fails++; $display("FAIL perf_wait got=%0d exp=12", perf_wait); end
`endif
    endtask

    task automatic test_core_write;
        int k = 0;
        @(negedge ph1); q_pop = 1; mem_ready = 0;
        @(negedge ph1); q_pop = 0; #1;
        while (!mem_read_en && k < 10) begin @(negedge ph1); #1; k++; end
        tests++; if (mem_read_en !== 1) begin fails++; $display("FAIL cw_issue got=%b exp=1", mem_read_en); end
        core_req = 1; core_we = 1; core_addr = 16'h00FF; core_wdata = 8'hA5; #1;
        tests++; if ({mem_write_en, mem_addr} !== {1'b0, 16'h0304}) begin fails++; $display("FAIL cw_hold got=%b/%h exp=0/0304", mem_write_en, mem_addr); end
        @(negedge ph1); #1;
        tests++; if ({mem_read_en, core_ack, mem_addr} !== {2'b10, 16'h0304}) begin fails++; $display("FAIL cw_wait got=%b%b/%h exp=10/0304", mem_read_en, core_ack, mem_addr); end
        @(negedge ph1); mem_ready = 1; #1;
        tests++; if ({mem_read_en, mem_write_en, core_ack, mem_addr} !== {3'b100, 16'h0304}) begin fails++; $display("FAIL cw_fetch_first got=%b%b%b/%h exp=100/0304", mem_read_en, mem_write_en, core_ack, mem_addr); end
        @(negedge ph1); #1;
        tests++; if ({mem_read_en, mem_write_en, core_ack, mem_addr, mem_data_out} !== {3'b011, 16'h00FF, 8'hA5}) begin fails++; $display("FAIL cw_write got=%b%b%b/%h/%h exp=011/00ff/a5", mem_read_en, mem_write_en, core_ack, mem_addr, mem_data_out); end
        core_req = 0; core_we = 0;
        @(negedge ph1); #1;
        tests++; if ({core_ack, mem_write_en, q_count} !== {2'b00, 3'd4}) begin fails++; $display("FAIL cw_ack_pulse got=%b%b/%0d exp=00/4", core_ack, mem_write_en, q_count); end
    endtask

    task automatic test_flush_wrap;
        logic [AW-1:0] exp_pc [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        int k = 0;
        @(negedge ph1); q_pop = 1; mem_ready = 0;
        @(negedge ph1); q_pop = 0; #1;
        while (!mem_read_en && k < 10) begin @(negedge ph1); #1; k++; end
        flush = 1; flush_pc = 16'hFFFE;
        @(negedge ph1); flush = 0; mem_ready = 1; #1;
        tests++; if ({q_count, q_valid, mem_read_en, mem_addr} !== {3'd0, 2'b01, 16'h0305}) begin fails++; $display("FAIL fw_pending got=%0d/%b/%b/%h exp=0/0/1/0305", q_count, q_valid, mem_read_en, mem_addr); end
        @(negedge ph1); #1;
        tests++; if ({q_count, mem_read_en, mem_addr} !== {3'd0, 1'b1, 16'hFFFE}) begin fails++; $display("FAIL fw_discard got=%0d/%b/%h exp=0/1/fffe", q_count, mem_read_en, mem_addr); end
        repeat (6) @(negedge ph1);
        #1;
        tests++; if (q_count !== 4) begin fails++; $display("FAIL fw_refill got=%0d exp=4", q_count); end
        for (int i = 0; i < 3; i++) begin
            @(negedge ph1); q_pop = 1; #1;
            tests++; if ({q_pc, q_data} !== {exp_pc[i], exp_pc[i][7:0] ^ exp_pc[i][15:8]}) begin fails++; $display("FAIL fw_seq%0d got=%h/%h exp=%h", i, q_pc, q_data, exp_pc[i]); end
        end
        @(negedge ph1); q_pop = 0;
    endtask

    task automatic test_full_pop_flush;
        int k = 0;
        mem_ready = 1;
        repeat (8) @(negedge ph1);
        #1;
        tests++; if (q_count !== 4) begin fails++; $display("FAIL fpf_full got=%0d exp=4", q_count); end
        q_pop = 1; flush = 1; flush_pc = 16'h1234;
        @(negedge ph1); q_pop = 0; flush = 0; #1;
        tests++; if ({q_count, q_valid} !== {3'd0, 1'b0}) begin fails++; $display("FAIL fpf_empty got=%0d/%b exp=0/0", q_count, q_valid); end
        while (!mem_read_en && k < 10) begin @(negedge ph1); #1; k++; end
        tests++; if ({mem_read_en, mem_addr} !== {1'b1, 16'h1234}) begin fails++; $display("FAIL fpf_next got=%b/%h exp=1/1234", mem_read_en, mem_addr); end
    endtask

    task automatic test_reset_mid_core;
        int k = 0;
        @(negedge ph1); q_pop = 0; core_req = 1; core_we = 0; core_addr = 16'h4000; mem_ready = 1;
        do begin @(negedge ph1); mem_ready = 0; #1; k++; end while (!(mem_read_en && mem_addr == 16'h4000) && k < 10);
        tests++; if ({mem_read_en, mem_addr} !== {1'b1, 16'h4000}) begin fails++; $display("FAIL rc_core got=%b/%h exp=1/4000", mem_read_en, mem_addr); end
        #2; reset = 1; #1;
        tests++; if ({mem_read_en, mem_write_en, core_ack, q_valid, q_count} !== 7'd0) begin fails++; $display("FAIL rc_async got=%b%b%b%b/%0d exp=0000/0", mem_read_en, mem_write_en, core_ack, q_valid, q_count); end
        mem_ready = 1; #1;
        tests++; if (core_ack !== 0) begin fails++; $display("FAIL rc_no_ack got=%b exp=0", core_ack); end
        @(negedge ph1);
        tests++; if ({core_ack, mem_read_en, mem_write_en} !== 3'b000) begin fails++; $display("FAIL rc_held got=%b%b%b exp=000", core_ack, mem_read_en, mem_write_en); end
        core_req = 0; reset = 0; k = 0; #1;
        while (!mem_read_en && k < 10) begin @(negedge ph1); #1; k++; end
        tests++; if ({mem_read_en, core_ack, mem_addr} !== {2'b10, 16'h0200}) begin fails++; $display("FAIL rc_restart got=%b%b/%h exp=10/0200", mem_read_en, core_ack, mem_addr); end
    endtask

    task automatic test_random;
        logic [DW+AW-1:0] mq[$];
        logic [DW+AW-1:0] ent;
        logic [AW-1:0] ptr = 16'h0200, inflight = '0;
        logic busy = 0, discard = 0, comp;
        @(negedge ph1); reset = 1; q_pop = 0; flush = 0; core_req = 0; core_we = 0;
        @(negedge ph1); reset = 0;
        repeat (2000) begin
            @(negedge ph1);
            mem_ready = $urandom_range(0, 9) < 7;
            q_pop = $urandom_range(0, 1) == 1;
            flush = $urandom_range(0, 39) == 0;
            flush_pc = 16'($urandom);
            salt = 8'($urandom);
            #1;
            tests++; if (q_count !== CW'(mq.size())) begin fails++; $display("FAIL rnd_count got=%0d exp=%0d", q_count, mq.size()); end
            if (mq.size() > 0) begin
                ent = mq[0];
                tests++; if ({q_valid, q_data, q_pc} !== {1'b1, ent}) begin fails++; $display("FAIL rnd_head got=%b/%h/%h exp=1/%h", q_valid, q_data, q_pc, ent); end
            end else begin
                tests++; if (q_valid !== 0) begin fails++; $display("FAIL rnd_empty got=%b exp=0", q_valid); end
            end
            if (mem_read_en && !busy) begin
                inflight = ptr;
                tests++; if (mq.size() >= DEPTH) begin fails++; $display("FAIL rnd_issue_full got=%0d exp<%0d", mq.size(), DEPTH); end
            end
            if (mem_read_en) begin
                tests++; if ({mem_write_en, mem_addr} !== {1'b0, inflight}) begin fails++; $display("FAIL rnd_addr got=%b/%h exp=0/%h", mem_write_en, mem_addr, inflight); end
            end
            comp = mem_read_en && mem_ready;
            if (q_pop && mq.size() > 0) void'(mq.pop_front());
            if (comp && !discard && !flush) begin
                mq.push_back({inflight[7:0] ^ inflight[15:8] ^ salt, inflight});
                ptr = ptr + 16'd1;
            end
            if (comp) discard = 0;
            else if (flush && mem_read_en) discard = 1;
            if (flush) begin mq.delete(); ptr = flush_pc; end
            busy = mem_read_en && !mem_ready;
        end
        @(negedge ph1); q_pop = 0; flush = 0;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_wait;
        test_core_write;
        test_flush_wrap;
        test_full_pop_flush;
        test_reset_mid_core;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
